// File: rtl/senha_pkg.sv
// Shared types and constants for the password-enrollment block:
// FSM state encoding, report error codes and the reserved invalid password.
package senha_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SCAN   = 3'd1,
    S_WRITE  = 3'd2,
    S_CLEAR  = 3'd3,
    S_REPORT = 3'd4
  } state_t;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_DUP  = 2'd1;
  localparam logic [1:0] ERR_FULL = 2'd2;
  localparam logic [1:0] ERR_INV  = 2'd3;

  localparam logic [7:0] INVALID_SENHA = 8'h00;

endpackage

// File: rtl/slot_counter.sv
// Address counter shared by the duplicate scan and the erase sweep;
// clr takes priority over en and wraps naturally at 2**ADDR_W.
module slot_counter #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              en,
  output logic [ADDR_W-1:0] value
);

  logic [ADDR_W-1:0] value_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value_reg <= '0;
    end else if (clr) begin
      value_reg <= '0;
    end else if (en) begin
      value_reg <= value_reg + 1'b1;
    end
  end

  assign value = value_reg;

endmodule

// File: rtl/senha_writer.sv
// Enrolls 8-bit passwords into an external slot memory, rejecting duplicates,
// a full table and the reserved 0x00 value; can also erase every slot.
module senha_writer
  import senha_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enter,
  input  logic              clear,
  input  logic [7:0]        senha,
  input  logic [7:0]        out_mem,
  output logic [ADDR_W-1:0] addr,
  output logic [7:0]        data_mem,
  output logic              we,
  output logic              busy,
  output logic              done,
  output logic              ok,
  output logic [1:0]        err,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W:0]   DEPTH_C   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   ONE_C     = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state_reg, state_next;
  logic [ADDR_W:0]   count_reg;
  logic [7:0]        senha_reg;
  logic              ok_reg;
  logic [1:0]        err_reg;
  logic              rpt_ok;
  logic [1:0]        rpt_err;

  logic [ADDR_W-1:0] scan_addr;
  logic              scan_clr;
  logic              scan_en;
  logic              scan_hit;
  logic              scan_last;

  assign scan_hit  = (out_mem == senha_reg);
  assign scan_last = ({1'b0, scan_addr} == (count_reg - ONE_C));

  slot_counter #(
    .ADDR_W(ADDR_W)
  ) u_slot_counter (
    .clk   (clk),
    .reset (reset),
    .clr   (scan_clr),
    .en    (scan_en),
    .value (scan_addr)
  );

  // Scan address restarts from 0 on every pass through IDLE.
  always_comb begin
    scan_clr = 1'b0;
    scan_en  = 1'b0;
    case (state_reg)
      S_IDLE:  scan_clr = 1'b1;
      S_SCAN:  scan_en  = !scan_hit && !scan_last;
      S_CLEAR: scan_en  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    rpt_ok     = 1'b0;
    rpt_err    = ERR_NONE;
    case (state_reg)
      S_IDLE: begin
        if (enter) begin
          if (senha == INVALID_SENHA) begin
            state_next = S_REPORT;
            rpt_err    = ERR_INV;
          end else if (count_reg == DEPTH_C) begin
            state_next = S_REPORT;
            rpt_err    = ERR_FULL;
          end else if (count_reg != '0) begin
            state_next = S_SCAN;
          end else begin
            state_next = S_WRITE;
          end
        end else if (clear) begin
          state_next = S_CLEAR;
        end
      end
      S_SCAN: begin
        if (scan_hit) begin
          state_next = S_REPORT;
          rpt_err    = ERR_DUP;
        end else if (scan_last) begin
          state_next = S_WRITE;
        end
      end
      S_WRITE: begin
        state_next = S_REPORT;
        rpt_ok     = 1'b1;
      end
      S_CLEAR: begin
        if (scan_addr == LAST_ADDR) begin
          state_next = S_REPORT;
          rpt_ok     = 1'b1;
        end
      end
      S_REPORT: state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Report qualifiers are captured on the deciding transition and held through REPORT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
      senha_reg <= INVALID_SENHA;
      ok_reg    <= 1'b0;
      err_reg   <= ERR_NONE;
    end else begin
      if (state_reg == S_IDLE && enter) begin
        senha_reg <= senha;
      end
      if (state_next == S_REPORT && state_reg != S_REPORT) begin
        ok_reg  <= rpt_ok;
        err_reg <= rpt_err;
      end
      if (state_reg == S_WRITE) begin
        count_reg <= count_reg + ONE_C;
      end else if (state_reg == S_CLEAR && scan_addr == LAST_ADDR) begin
        count_reg <= '0;
      end
    end
  end

  always_comb begin
    addr     = '0;
    data_mem = 8'h00;
    we       = 1'b0;
    busy     = (state_reg != S_IDLE);
    done     = 1'b0;
    ok       = 1'b0;
    err      = ERR_NONE;
    case (state_reg)
      S_SCAN: addr = scan_addr;
      S_WRITE: begin
        addr     = count_reg[ADDR_W-1:0];
        data_mem = senha_reg;
        we       = 1'b1;
      end
      S_CLEAR: begin
        addr = scan_addr;
        we   = 1'b1;
      end
      S_REPORT: begin
        done = 1'b1;
        ok   = ok_reg;
        err  = err_reg;
      end
      default: ;
    endcase
  end

  assign count = count_reg;

endmodule

// File: tb/tb_senha_writer.sv
// Directed bench for senha_writer with a combinational-read slot memory model;
// each operation's latency, write traffic and report are checked against hand values.
module tb_senha_writer;

  logic       clk;
  logic       reset;
  logic       enter;
  logic       clear;
  logic [7:0] senha;
  logic [7:0] out_mem;
  logic [3:0] addr;
  logic [7:0] data_mem;
  logic       we;
  logic       busy;
  logic       done;
  logic       ok;
  logic [1:0] err;
  logic [4:0] count;

  int vectors;
  int miscompares;

  logic [7:0] mem [16];

  senha_writer #(
    .ADDR_W(4),
    .DEPTH (16)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .enter    (enter),
    .clear    (clear),
    .senha    (senha),
    .out_mem  (out_mem),
    .addr     (addr),
    .data_mem (data_mem),
    .we       (we),
    .busy     (busy),
    .done     (done),
    .ok       (ok),
    .err      (err),
    .count    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign out_mem = mem[addr];
  always @(posedge clk) begin
    if (we) mem[addr] <= data_mem;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One enroll (is_clear=0) or clear (is_clear=1) request, monitored until done.
  task automatic run_op(input string tag, input logic is_clear, input logic [7:0] s,
                        input int exp_lat, input logic exp_ok, input logic [1:0] exp_err,
                        input int exp_we, input logic [4:0] exp_count, input logic [3:0] exp_waddr);
    int lat;
    int we_n;
    logic [3:0] waddr;
    logic [7:0] wdata;
    logic bad_sweep;
    we_n = 0;
    waddr = '0;
    wdata = '0;
    bad_sweep = 1'b0;
    enter = !is_clear;
    clear = is_clear;
    senha = s;
    @(posedge clk); #1;
    enter = 1'b0;
    clear = 1'b0;
    senha = ~s;
    lat = 1;
    check({tag, ".busy"}, 32'(busy), 32'd1);
    while (!done && lat < 40) begin
      if (we) begin
        if (we_n == 0) begin
          waddr = addr;
          wdata = data_mem;
        end
        if (is_clear && (addr !== 4'(we_n) || data_mem !== 8'h00)) bad_sweep = 1'b1;
        we_n++;
      end
      @(posedge clk); #1;
      lat++;
    end
    check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    check({tag, ".ok"}, 32'(ok), 32'(exp_ok));
    check({tag, ".err"}, 32'(err), 32'(exp_err));
    check({tag, ".we_cycles"}, 32'(we_n), 32'(exp_we));
    check({tag, ".count"}, 32'(count), 32'(exp_count));
    check({tag, ".rpt_idle_bus"}, {22'd0, we, addr, data_mem}, 32'd0);
    if (exp_we == 1) begin
      check({tag, ".waddr"}, 32'(waddr), 32'(exp_waddr));
      check({tag, ".wdata"}, 32'(wdata), 32'(s));
    end
    if (is_clear) check({tag, ".sweep"}, 32'(bad_sweep), 32'd0);
    @(posedge clk); #1;
    check({tag, ".after"}, {27'd0, done, busy, ok, err}, 32'd0);
    $display("op %s senha=%02h lat=%0d we=%0d count=%0d", tag, s, lat, we_n, count);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("reset.outputs", {14'd0, busy, done, ok, err, we, addr, data_mem}, 32'd0);
    check("reset.count", 32'(count), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    $display("reset applied");
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    reset = 1'b0;
    enter = 1'b0;
    clear = 1'b0;
    senha = 8'h00;
    #2;
    do_reset();

    // Empty table: direct write to slot 0.
    run_op("enroll_5a", 1'b0, 8'h5A, 2, 1'b1, 2'd0, 1, 5'd1, 4'd0);
    check("mem0_5a", 32'(mem[0]), 32'h5A);

    do_reset();
    run_op("enroll_11", 1'b0, 8'h11, 2, 1'b1, 2'd0, 1, 5'd1, 4'd0);
    run_op("enroll_22", 1'b0, 8'h22, 3, 1'b1, 2'd0, 1, 5'd2, 4'd1);
    run_op("enroll_33", 1'b0, 8'h33, 4, 1'b1, 2'd0, 1, 5'd3, 4'd2);
    run_op("dup_22", 1'b0, 8'h22, 3, 1'b0, 2'd1, 0, 5'd3, 4'd0);
    run_op("invalid_00", 1'b0, 8'h00, 1, 1'b0, 2'd3, 0, 5'd3, 4'd0);
    run_op("enroll_44", 1'b0, 8'h44, 5, 1'b1, 2'd0, 1, 5'd4, 4'd3);
    run_op("enroll_55", 1'b0, 8'h55, 6, 1'b1, 2'd0, 1, 5'd5, 4'd4);
    check("mem4_55", 32'(mem[4]), 32'h55);

    run_op("clear", 1'b1, 8'h00, 17, 1'b1, 2'd0, 16, 5'd0, 4'd0);
    check("mem2_cleared", 32'(mem[2]), 32'h00);
    run_op("enroll_42", 1'b0, 8'h42, 2, 1'b1, 2'd0, 1, 5'd1, 4'd0);

    // Fill all 16 slots with 0x01..0x10.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      run_op("fill", 1'b0, 8'(i + 1), (i == 0) ? 2 : i + 2, 1'b1, 2'd0, 1, 5'(i + 1), 4'(i));
    end
    run_op("full_77", 1'b0, 8'h77, 1, 1'b0, 2'd2, 0, 5'd16, 4'd0);
    run_op("full_invalid", 1'b0, 8'h00, 1, 1'b0, 2'd3, 0, 5'd16, 4'd0);

    // Abort mid-scan with 8 occupied slots, at slot 4.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      run_op("fill8", 1'b0, 8'hA0 + 8'(i), (i == 0) ? 2 : i + 2, 1'b1, 2'd0, 1, 5'(i + 1), 4'(i));
    end
    enter = 1'b1;
    senha = 8'hEE;
    @(posedge clk); #1;
    enter = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    check("midscan.addr", 32'(addr), 32'd4);
    check("midscan.busy", 32'(busy), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("abort.outputs", {14'd0, busy, done, ok, err, we, addr, data_mem}, 32'd0);
    check("abort.count", 32'(count), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("abort.quiet", {30'd0, done, busy}, 32'd0);
      @(posedge clk); #1;
    end
    $display("reset mid-scan applied");
    run_op("post_abort_42", 1'b0, 8'h42, 2, 1'b1, 2'd0, 1, 5'd1, 4'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
